// File: rtl/tweezer_pkg.sv
// Shared definitions for the tweezer PI parameter path: sequencer states and
// the host register map.
package tweezer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_SAMPLE = 3'd1,
      ST_APPLY_KP    = 3'd2,
      ST_APPLY_KI    = 3'd3,
      ST_RAMP        = 3'd4,
      ST_DONE        = 3'd5
   } seq_state_t;

   localparam logic [1:0] ADDR_KP     = 2'd0;
   localparam logic [1:0] ADDR_KI     = 2'd1;
   localparam logic [1:0] ADDR_TARGET = 2'd2;
   localparam logic [1:0] ADDR_STEP   = 2'd3;

   // kp, ki and target carry dirty flags; the ramp step does not
   localparam int NUM_DIRTY = 3;

endpackage

// File: rtl/setpoint_ramp.sv
// Slew limiter: walks the setpoint toward a loaded target by |step| per sample,
// landing exactly on target; a zero step jumps straight there.
module setpoint_ramp
   import tweezer_pkg::*;
#(
   parameter int inputBitSize = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [inputBitSize-1:0] load_target,
   input  logic [inputBitSize-1:0] load_step,
   input  logic                    run,
   input  logic                    sample_valid,
   output logic [inputBitSize-1:0] setpoint,
   output logic                    at_target
);

   localparam int WX  = inputBitSize + 1;
   localparam int MSB = inputBitSize - 1;

   logic [inputBitSize-1:0] setpoint_reg;
   logic [inputBitSize-1:0] target_reg;
   logic [inputBitSize-1:0] step_reg;
   logic [inputBitSize-1:0] setpoint_next;

   // One extra bit keeps full-scale differences (e.g. max to min) from wrapping
   logic signed [WX-1:0] setpoint_ext;
   logic signed [WX-1:0] target_ext;
   logic signed [WX-1:0] step_ext;
   logic signed [WX-1:0] diff;
   logic signed [WX-1:0] diff_abs;
   logic signed [WX-1:0] step_abs;
   logic signed [WX-1:0] setpoint_sum;
   logic                 step_zero;
   logic                 advance;

   assign setpoint  = setpoint_reg;
   assign at_target = (setpoint_reg == target_reg);

   always_comb begin
      setpoint_ext  = $signed({setpoint_reg[MSB], setpoint_reg});
      target_ext    = $signed({target_reg[MSB], target_reg});
      step_ext      = $signed({step_reg[MSB], step_reg});
      diff          = target_ext - setpoint_ext;
      diff_abs      = diff[WX-1] ? -diff : diff;
      step_abs      = step_ext[WX-1] ? -step_ext : step_ext;
      step_zero     = (step_reg == '0);
      setpoint_sum  = diff[WX-1] ? (setpoint_ext - step_abs) : (setpoint_ext + step_abs);
      setpoint_next = setpoint_sum[MSB:0];
      if (step_zero || (diff_abs <= step_abs)) begin
         setpoint_next = target_reg;
      end
      advance = run && !at_target && (step_zero || sample_valid);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         setpoint_reg <= '0;
         target_reg   <= '0;
         step_reg     <= '0;
      end else begin
         if (load) begin
            target_reg <= load_target;
            step_reg   <= load_step;
         end
         if (advance) begin
            setpoint_reg <= setpoint_next;
         end
      end
   end

endmodule

// File: rtl/pi_param_sequencer.sv
// Applies host-written PI coefficients and setpoint to a running PI loop,
// changing them only at controller sample boundaries.
module pi_param_sequencer
   import tweezer_pkg::*;
#(
   parameter int coeffBitSize = 10,
   parameter int inputBitSize = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_valid,
   input  logic [1:0]              wr_addr,
   input  logic [inputBitSize-1:0] wr_data,
   input  logic                    commit,
   input  logic                    sample_valid,
   output logic [coeffBitSize-1:0] PI_kp,
   output logic [coeffBitSize-1:0] PI_ki,
   output logic                    PI_kp_update,
   output logic                    PI_ki_update,
   output logic [inputBitSize-1:0] PI_setpoint,
   output logic                    busy,
   output logic                    commit_done
);

   seq_state_t state_reg;
   seq_state_t state_next;

   logic [coeffBitSize-1:0] kp_shadow_reg;
   logic [coeffBitSize-1:0] ki_shadow_reg;
   logic [inputBitSize-1:0] target_shadow_reg;
   logic [inputBitSize-1:0] step_shadow_reg;
   logic [NUM_DIRTY-1:0]    dirty_reg;
   logic [NUM_DIRTY-1:0]    snap_dirty_reg;
   logic [coeffBitSize-1:0] kp_snap_reg;
   logic [coeffBitSize-1:0] ki_snap_reg;
   logic                    pending_reg;
   logic [coeffBitSize-1:0] PI_kp_reg;
   logic [coeffBitSize-1:0] PI_ki_reg;
   logic                    kp_update_reg;
   logic                    ki_update_reg;

   logic [3:0]              wr_hit;
   logic [NUM_DIRTY-1:0]    dirty_merged;
   logic [coeffBitSize-1:0] kp_merged;
   logic [coeffBitSize-1:0] ki_merged;
   logic [inputBitSize-1:0] target_merged;
   logic [inputBitSize-1:0] step_merged;
   logic [inputBitSize-1:0] ramp_load_target;
   logic                    start;
   logic                    kp_load;
   logic                    ki_load;
   logic                    ramp_at_target;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wr_hit
         assign wr_hit[gi] = wr_valid && (wr_addr == 2'(gi));
      end
      // A write landing with the commit is part of the snapshot
      for (gi = 0; gi < NUM_DIRTY; gi++) begin : g_dirty
         assign dirty_merged[gi] = dirty_reg[gi] | wr_hit[gi];
      end
   endgenerate

   assign kp_merged     = wr_hit[ADDR_KP]     ? wr_data[coeffBitSize-1:0] : kp_shadow_reg;
   assign ki_merged     = wr_hit[ADDR_KI]     ? wr_data[coeffBitSize-1:0] : ki_shadow_reg;
   assign target_merged = wr_hit[ADDR_TARGET] ? wr_data : target_shadow_reg;
   assign step_merged   = wr_hit[ADDR_STEP]   ? wr_data : step_shadow_reg;

   // An untouched target holds the ramp where it is
   assign ramp_load_target = dirty_merged[ADDR_TARGET] ? target_merged : PI_setpoint;

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      kp_load    = 1'b0;
      ki_load    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (commit || pending_reg) begin
               start      = 1'b1;
               state_next = ST_WAIT_SAMPLE;
            end
         end
         ST_WAIT_SAMPLE: begin
            if (sample_valid) begin
               kp_load    = snap_dirty_reg[ADDR_KP];
               state_next = ST_APPLY_KP;
            end
         end
         ST_APPLY_KP: begin
            ki_load    = snap_dirty_reg[ADDR_KI];
            state_next = ST_APPLY_KI;
         end
         ST_APPLY_KI: state_next = ST_RAMP;
         ST_RAMP: begin
            if (ramp_at_target) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Loads are registered on entry, so value and pulse are visible together
   // during APPLY_KP / APPLY_KI.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg         <= ST_IDLE;
         kp_shadow_reg     <= '0;
         ki_shadow_reg     <= '0;
         target_shadow_reg <= '0;
         step_shadow_reg   <= '0;
         dirty_reg         <= '0;
         snap_dirty_reg    <= '0;
         kp_snap_reg       <= '0;
         ki_snap_reg       <= '0;
         pending_reg       <= 1'b0;
         PI_kp_reg         <= '0;
         PI_ki_reg         <= '0;
         kp_update_reg     <= 1'b0;
         ki_update_reg     <= 1'b0;
      end else begin
         state_reg         <= state_next;
         kp_shadow_reg     <= kp_merged;
         ki_shadow_reg     <= ki_merged;
         target_shadow_reg <= target_merged;
         step_shadow_reg   <= step_merged;
         if (start) begin
            kp_snap_reg    <= kp_merged;
            ki_snap_reg    <= ki_merged;
            snap_dirty_reg <= dirty_merged;
            dirty_reg      <= '0;
            pending_reg    <= 1'b0;
         end else begin
            dirty_reg <= dirty_merged;
            if (commit) begin
               pending_reg <= 1'b1;
            end
         end
         kp_update_reg <= kp_load;
         ki_update_reg <= ki_load;
         if (kp_load) begin
            PI_kp_reg <= kp_snap_reg;
         end
         if (ki_load) begin
            PI_ki_reg <= ki_snap_reg;
         end
      end
   end

   setpoint_ramp #(
      .inputBitSize(inputBitSize)
   ) u_ramp (
      .clk         (clk),
      .reset       (reset),
      .load        (start),
      .load_target (ramp_load_target),
      .load_step   (step_merged),
      .run         (state_reg == ST_RAMP),
      .sample_valid(sample_valid),
      .setpoint    (PI_setpoint),
      .at_target   (ramp_at_target)
   );

   assign PI_kp        = PI_kp_reg;
   assign PI_ki        = PI_ki_reg;
   assign PI_kp_update = kp_update_reg;
   assign PI_ki_update = ki_update_reg;
   assign busy         = (state_reg != ST_IDLE);
   assign commit_done  = (state_reg == ST_DONE);

endmodule
